bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per clock, subtract 3 from any BCD digit >= 8.
- It is the decode counterpart of the calculator's binary-to-BCD result path.
- It converts a packed 4-digit BCD operand (keypad/entry side) into a binary operand for the arithmetic stage.
- It uses a start/done handshake, replacing wide combinational digit*weight multipliers with a small iterative datapath.

---
 rtl/bcd_to_bin_seq.sv | 114 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Accepts a packed BCD operand on start and pulses done with the binary value BIN_W cycles later.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [BCD_W-1:0]    r_bcdReg;
    logic [BIN_W-1:0]    r_binReg;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [BIN_W-1:0]    r_binOut;

    logic [BCD_W+BIN_W-1:0] w_shifted;
    logic [BCD_W-1:0]       w_bcdNext;
    logic [BIN_W-1:0]       w_binNext;
    logic                   w_badDigit;

    // One reverse double-dabble step: shift the pair right, then pull back any digit that reached 8.
    always_comb begin
        w_shifted  = {r_bcdReg, r_binReg} >> 1;
        w_binNext  = w_shifted[BIN_W-1:0];
        w_bcdNext  = w_shifted[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcdNext[4*i+3]) begin
                w_bcdNext[4*i +: 4] = w_bcdNext[4*i +: 4] - 4'd3;
            end
        end
        w_badDigit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                w_badDigit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bcdReg <= '0;
            r_binReg <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_binOut <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        // Malformed operands skip the shifter entirely and report straight away.
                        if (w_badDigit) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_binOut <= '0;
                        end else begin
                            r_bcdReg <= bcd_in;
                            r_binReg <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_bcdReg <= w_bcdNext;
                    r_binReg <= w_binNext;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_binOut <= w_binNext;
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bin_out = r_binOut;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: the driver queues model results, a monitor checks each done pulse.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    int nVec;
    int nMiss;
    int doneCount;
    logic [14:0] expQ[$];

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal weight sum of the digits, or an error flag if any digit is not decimal.
    function automatic logic [14:0] refModel(input logic [15:0] v);
        int sum;
        int weight;
        bit bad;
        sum = 0;
        weight = 1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) bad = 1;
            sum += d * weight;
            weight *= 10;
        end
        if (bad) return {1'b1, 14'd0};
        return {1'b0, 14'(sum)};
    endfunction

    task automatic compare(input string name, input int got, input int want);
        nVec++;
        if (got != want) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            doneCount++;
            if (expQ.size() == 0) begin
                nVec++;
                nMiss++;
                $display("[TB] FAIL unexpected_done: got err=%0b bin=0x%0h want no pulse", err, bin_out);
            end else begin
                logic [14:0] want;
                want = expQ.pop_front();
                compare("result", int'({err, bin_out}), int'(want));
            end
        end
    end

    // Called at a negedge with the DUT able to accept; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] v, input bit expectDone);
        bcd_in = v;
        start  = 1'b1;
        if (expectDone) expQ.push_back(refModel(v));
        @(posedge clk);
    endtask

    // Follows the conversion from its accepting edge until done, checking busy and latency.
    task automatic waitDone(input int expLat, input int pulseAt, input logic [15:0] pulseVal,
                            input bit holdStart);
        int lat;
        bit seen;
        bit busyOk;
        seen = 0;
        busyOk = 1;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (!holdStart && lat == 0) start = 1'b0;
            if (pulseAt >= 0 && lat == pulseAt) begin
                start  = 1'b1;
                bcd_in = pulseVal;
            end
            if (pulseAt >= 0 && lat == pulseAt + 1) start = 1'b0;
            if (busy !== (lat < expLat)) busyOk = 0;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL timeout: got no done within 40 cycles want done after %0d", expLat);
        end else begin
            compare("latency", lat, expLat);
        end
        compare("busy_profile", int'(busyOk), 1);
    endtask

    // Done must drop after one cycle and the result must stay put while idle.
    task automatic checkOutput(input logic [13:0] expBin, input logic expErr);
        @(negedge clk);
        compare("done_pulse", int'(done), 0);
        repeat (2) @(negedge clk);
        compare("hold", int'({err, bin_out}), int'({expErr, expBin}));
    endtask

    task automatic runOne(input logic [15:0] v, input bit hold);
        logic [14:0] r;
        r = refModel(v);
        applyStimulus(v, 1'b1);
        waitDone(r[14] ? 0 : 14, -1, 16'h0, 1'b0);
        if (hold) checkOutput(r[13:0], r[14]);
    endtask

    initial begin
        logic [15:0] v;
        int startDone;
        nVec = 0;
        nMiss = 0;
        doneCount = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0;

        #1;
        compare("reset_async", int'({busy, done, err, bin_out}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            compare("reset_idle", int'({busy, done, err, bin_out}), 0);
        end

        runOne(16'h1234, 1'b1);
        compare("dir_1234", int'(bin_out), 14'h04D2);
        runOne(16'h0000, 1'b1);
        runOne(16'h0001, 1'b1);
        runOne(16'h9999, 1'b1);
        compare("dir_9999", int'(bin_out), 14'h270F);
        runOne(16'h1000, 1'b1);
        compare("dir_1000", int'(bin_out), 14'h03E8);

        runOne(16'h12A4, 1'b1);
        compare("dir_err", int'(err), 1);
        runOne(16'hF000, 1'b1);
        runOne(16'h0007, 1'b1);
        compare("dir_after_err", int'({err, bin_out}), 7);

        // Start pulsed mid-conversion must be dropped.
        applyStimulus(16'h0250, 1'b1);
        waitDone(14, 5, 16'h0042, 1'b0);
        checkOutput(14'd250, 1'b0);
        repeat (20) @(negedge clk);

        // Start held high re-triggers from the done cycle.
        applyStimulus(16'h0005, 1'b1);
        for (int r = 0; r < 3; r++) begin
            waitDone(14, -1, 16'h0, 1'b1);
            if (r < 2) begin
                expQ.push_back(refModel(16'h0005));
                @(posedge clk);
            end else begin
                start = 1'b0;
            end
        end
        checkOutput(14'd5, 1'b0);

        // Reset in the middle of a conversion aborts it silently.
        applyStimulus(16'h0500, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        compare("busy_before_abort", int'(busy), 1);
        startDone = doneCount;
        rst_n = 1'b0;
        #1;
        compare("abort_outputs", int'({busy, done, err, bin_out}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        compare("abort_no_done", doneCount, startDone);
        runOne(16'h0500, 1'b1);
        compare("dir_0500", int'(bin_out), 14'h01F4);

        // Random operands, mostly valid, with back-to-back starts from the done cycle.
        for (int i = 0; i < 1000; i++) begin
            v = 16'h0;
            for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) begin
                int pos;
                pos = int'($urandom_range(0, 3));
                v[4*pos +: 4] = 4'($urandom_range(10, 15));
            end
            runOne(v, $urandom_range(0, 9) == 0);
        end

        start = 1'b0;
        repeat (30) @(negedge clk);
        compare("queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
